// File: rtl/video_timing_pkg.sv
// Shared video timing constants, stream lock states and timing decode payload.
package video_timing_pkg;

   localparam int unsigned H_ACTIVE_1080 = 1920;
   localparam int unsigned H_FP_1080     = 88;
   localparam int unsigned H_SYNC_1080   = 44;
   localparam int unsigned H_BP_1080     = 148;
   localparam int unsigned V_ACTIVE_1080 = 1080;
   localparam int unsigned V_FP_1080     = 4;
   localparam int unsigned V_SYNC_1080   = 5;
   localparam int unsigned V_BP_1080     = 36;

   localparam int unsigned CNT_W = 12;
   localparam int unsigned PIX_W = 24;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ARMED    = 2'd1,
      RUN      = 2'd2
   } stream_state_e;

   // Per-cycle decode of the raster position.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } timing_t;

endpackage

// File: rtl/stream2rgb_if.sv
// AXI4-Stream video beat bundle (tuser = start of frame, tlast = end of line).
interface stream2rgb_if
   import video_timing_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tuser;
   logic              tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster counters with active / sync region decode.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_1080,
   parameter int unsigned H_FP     = H_FP_1080,
   parameter int unsigned H_SYNC   = H_SYNC_1080,
   parameter int unsigned H_BP     = H_BP_1080,
   parameter int unsigned V_ACTIVE = V_ACTIVE_1080,
   parameter int unsigned V_FP     = V_FP_1080,
   parameter int unsigned V_SYNC   = V_SYNC_1080,
   parameter int unsigned V_BP     = V_BP_1080
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output timing_t          timing_c
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

   // Line counter advances only on the horizontal wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
         h_cnt_d = '0;
         if (v_cnt_q == CNT_W'(V_TOTAL - 1)) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   always_comb begin
      timing_c        = '0;
      timing_c.active = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
      timing_c.hs     = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END));
      timing_c.vs     = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END));
   end

   assign h_cnt = h_cnt_q;
   assign v_cnt = v_cnt_q;

endmodule

// File: rtl/stream2rgb.sv
// AXI4-Stream video to parallel RGB: locks the stream to a free-running raster at SOF.
module stream2rgb
   import video_timing_pkg::*;
#(
   parameter int unsigned       H_ACTIVE  = H_ACTIVE_1080,
   parameter int unsigned       H_FP      = H_FP_1080,
   parameter int unsigned       H_SYNC    = H_SYNC_1080,
   parameter int unsigned       H_BP      = H_BP_1080,
   parameter int unsigned       V_ACTIVE  = V_ACTIVE_1080,
   parameter int unsigned       V_FP      = V_FP_1080,
   parameter int unsigned       V_SYNC    = V_SYNC_1080,
   parameter int unsigned       V_BP      = V_BP_1080,
   parameter int unsigned       DATA_W    = PIX_W,
   parameter logic [DATA_W-1:0] BLANK_PIX = '0
) (
   input  logic              aclk,
   input  logic              areset_n,
   stream2rgb_if.slave       axis_s,
   output logic [DATA_W-1:0] rgb_data,
   output logic              rgb_HREF,
   output logic              rgb_HSYNC,
   output logic              rgb_VSYNC,
   output logic              locked,
   output logic              underflow,
   output logic              eol_err
);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   timing_t          timing_c;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk      (aclk),
      .rst_n    (areset_n),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .timing_c (timing_c)
   );

   stream_state_e     state_q, state_d;
   logic [DATA_W-1:0] rgb_data_q, rgb_data_d;
   logic              href_q, href_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              locked_q, locked_d;
   logic              underflow_q, underflow_d;
   logic              eol_err_q, eol_err_d;
   logic              tready_c;
   logic              frame_start_c;
   logic              line_end_c;

   assign frame_start_c = (h_cnt == '0) && (v_cnt == '0);
   assign line_end_c    = (h_cnt == CNT_W'(H_ACTIVE - 1));

   // ARMED joins RUN in the frame-start cycle itself so the SOF beat lands on pixel (0,0).
   always_comb begin
      state_d     = state_q;
      tready_c    = 1'b0;
      rgb_data_d  = BLANK_PIX;
      underflow_d = 1'b0;
      eol_err_d   = 1'b0;
      href_d      = timing_c.active;
      hsync_d     = timing_c.hs;
      vsync_d     = timing_c.vs;

      unique case (state_q)
         WAIT_SOF: begin
            tready_c = axis_s.tvalid & ~axis_s.tuser;
            if (axis_s.tvalid && axis_s.tuser) begin
               state_d = ARMED;
            end
         end
         ARMED, RUN: begin
            if ((state_q == RUN) || frame_start_c) begin
               state_d = RUN;
               if (timing_c.active) begin
                  if (axis_s.tvalid && axis_s.tuser && !frame_start_c) begin
                     // Early SOF: hold the beat and re-align at the next frame start.
                     state_d = ARMED;
                  end else if (axis_s.tvalid) begin
                     tready_c   = 1'b1;
                     rgb_data_d = axis_s.tdata;
                     eol_err_d  = (axis_s.tlast != line_end_c);
                  end else begin
                     underflow_d = 1'b1;
                     state_d     = WAIT_SOF;
                  end
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      locked_d = (state_d == RUN);
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q     <= WAIT_SOF;
         rgb_data_q  <= '0;
         href_q      <= 1'b0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         locked_q    <= 1'b0;
         underflow_q <= 1'b0;
         eol_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rgb_data_q  <= rgb_data_d;
         href_q      <= href_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         locked_q    <= locked_d;
         underflow_q <= underflow_d;
         eol_err_q   <= eol_err_d;
      end
   end

   // No beat is accepted while reset is held.
   assign axis_s.tready = areset_n & tready_c;

   assign rgb_data  = rgb_data_q;
   assign rgb_HREF  = href_q;
   assign rgb_HSYNC = hsync_q;
   assign rgb_VSYNC = vsync_q;
   assign locked    = locked_q;
   assign underflow = underflow_q;
   assign eol_err   = eol_err_q;

endmodule

// File: tb/tb_stream2rgb.sv
// Bench for stream2rgb on a reduced 14x7 raster with a behavioural lock/raster model.
module tb_stream2rgb;

   localparam int unsigned HA = 8, HF = 2, HSW = 2, HB = 2;
   localparam int unsigned VA = 4, VF = 1, VSW = 1, VB = 1;
   localparam int unsigned HT = HA + HF + HSW + HB;
   localparam int unsigned VT = VA + VF + VSW + VB;
   localparam int unsigned FRAME = HT * VT;
   localparam int unsigned NPIX = HA * VA;
   localparam int unsigned DW = 24;
   localparam int M_WAIT = 0, M_ARMED = 1, M_RUN = 2;

   logic          aclk = 1'b0;
   logic          areset_n = 1'b0;
   logic [DW-1:0] rgb_data;
   logic          rgb_HREF, rgb_HSYNC, rgb_VSYNC, locked, underflow, eol_err;

   stream2rgb_if #(.DATA_W(DW)) axis_s ();

   stream2rgb #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
      .DATA_W (DW), .BLANK_PIX (24'h000000)
   ) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .axis_s    (axis_s),
      .rgb_data  (rgb_data),
      .rgb_HREF  (rgb_HREF),
      .rgb_HSYNC (rgb_HSYNC),
      .rgb_VSYNC (rgb_VSYNC),
      .locked    (locked),
      .underflow (underflow),
      .eol_err   (eol_err)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   int unsigned   mt;
   int            mst;
   bit            src_on, drop_now, tlast_flip;
   int unsigned   src_idx;
   logic [DW-1:0] src_pix, last_sof_pix, held;

   logic [DW-1:0] s_data;
   logic          s_href, s_hs, s_vs, s_locked, s_uf, s_ee, s_tready;

   typedef struct {
      int unsigned t;
      logic        href;
      logic        hs;
      logic        vs;
   } tvec_t;
   tvec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=%h expected=%h", name, mt, act, exp);
      end
   endtask

   task automatic present();
      axis_s.tvalid = src_on && !drop_now;
      axis_s.tdata  = src_pix;
      axis_s.tuser  = (src_idx == 0);
      axis_s.tlast  = ((src_idx % HA) == HA - 1) ^ tlast_flip;
      if (src_idx == 0) last_sof_pix = src_pix;
   endtask

   task automatic sample();
      s_data   = rgb_data;
      s_href   = rgb_HREF;
      s_hs     = rgb_HSYNC;
      s_vs     = rgb_VSYNC;
      s_locked = locked;
      s_uf     = underflow;
      s_ee     = eol_err;
   endtask

   // One clock: raster position from elapsed cycles, lock behaviour from the stream rules.
   task automatic cycle();
      int unsigned   h, v;
      bit            tv, tu, tl, fs, act;
      logic          e_tr, e_uf, e_ee;
      logic [DW-1:0] e_d;
      int            nst;
      h   = mt % HT;
      v   = (mt / HT) % VT;
      present();
      tv  = src_on && !drop_now;
      tu  = (src_idx == 0);
      tl  = ((src_idx % HA) == HA - 1) ^ tlast_flip;
      fs  = (h == 0) && (v == 0);
      act = (h < HA) && (v < VA);
      e_tr = 1'b0; e_uf = 1'b0; e_ee = 1'b0; e_d = '0; nst = mst;
      if (mst == M_WAIT) begin
         e_tr = tv && !tu;
         if (tv && tu) nst = M_ARMED;
      end else if (mst == M_RUN || fs) begin
         nst = M_RUN;
         if (act) begin
            if (tv && tu && !fs) begin
               nst = M_ARMED;
            end else if (tv) begin
               e_tr = 1'b1;
               e_d  = src_pix;
               e_ee = (tl != (h == HA - 1));
            end else begin
               e_uf = 1'b1;
               nst  = M_WAIT;
            end
         end
      end
      #1;
      s_tready = axis_s.tready;
      chk("tready", 32'(s_tready), 32'(e_tr));
      @(posedge aclk);
      #1;
      sample();
      chk("rgb_data", 32'(s_data), 32'(e_d));
      chk("href", 32'(s_href), 32'(act));
      chk("hsync", 32'(s_hs), 32'((h >= HA + HF) && (h < HA + HF + HSW)));
      chk("vsync", 32'(s_vs), 32'((v >= VA + VF) && (v < VA + VF + VSW)));
      chk("locked", 32'(s_locked), 32'(nst == M_RUN));
      chk("underflow", 32'(s_uf), 32'(e_uf));
      chk("eol_err", 32'(s_ee), 32'(e_ee));
      mst = nst;
      mt++;
      if (e_tr) begin
         src_idx = (src_idx + 1) % NPIX;
         src_pix = DW'($urandom);
      end
      drop_now   = 1'b0;
      tlast_flip = 1'b0;
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      present();
      #1;
      chk("reset_tready", 32'(axis_s.tready), 32'(0));
      @(posedge aclk);
      #1;
      sample();
      chk("reset_outputs", {s_data, s_href, s_hs, s_vs, s_locked, s_uf, s_ee, 1'b0}, 32'(0));
      areset_n = 1'b1;
      mt  = 0;
      mst = M_WAIT;
   endtask

   task automatic wait_lock(input string name, input int unsigned budget);
      int unsigned n = 0;
      while (!s_locked && n < budget) begin
         cycle();
         n++;
      end
      chk(name, 32'(s_locked), 32'(1));
   endtask

   task automatic wait_pos(input string name, input int unsigned h, input int unsigned v,
                           input int unsigned budget);
      int unsigned n = 0;
      while (!((mt % HT) == h && ((mt / HT) % VT) == v && mst == M_RUN) && n < budget) begin
         cycle();
         n++;
      end
      chk(name, 32'(n < budget), 32'(1));
   endtask

   initial begin
      src_on = 0; drop_now = 0; tlast_flip = 0;
      src_idx = 0; src_pix = '0; last_sof_pix = '0; held = '0;
      mt = 0; mst = M_WAIT;
      s_locked = 0;

      tbl[0]  = '{0, 1, 0, 0};   tbl[1]  = '{7, 1, 0, 0};
      tbl[2]  = '{8, 0, 0, 0};   tbl[3]  = '{9, 0, 0, 0};
      tbl[4]  = '{10, 0, 1, 0};  tbl[5]  = '{11, 0, 1, 0};
      tbl[6]  = '{12, 0, 0, 0};  tbl[7]  = '{14, 1, 0, 0};
      tbl[8]  = '{55, 0, 0, 0};  tbl[9]  = '{56, 0, 0, 0};
      tbl[10] = '{70, 0, 0, 1};  tbl[11] = '{80, 0, 1, 1};
      tbl[12] = '{84, 0, 0, 0};  tbl[13] = '{98, 1, 0, 0};

      do_reset();

      // Raster decode with no source attached.
      for (int i = 0; i < 14; i++) begin
         while (mt <= tbl[i].t) cycle();
         chk("tbl_href", 32'(s_href), 32'(tbl[i].href));
         chk("tbl_hsync", 32'(s_hs), 32'(tbl[i].hs));
         chk("tbl_vsync", 32'(s_vs), 32'(tbl[i].vs));
      end

      // Source joins mid-frame at pixel 13.
      src_on = 1; src_idx = 13; src_pix = DW'($urandom);
      wait_lock("lock_mid_start", 3 * FRAME);
      chk("lock_at_frame_start", (mt - 1) % FRAME, 0);
      chk("first_pixel_is_sof", 32'(s_data), 32'(last_sof_pix));
      repeat (2 * FRAME) cycle();

      // One missing beat at line 2 pixel 5.
      wait_pos("reach_l2p5", 5, 2, 2 * FRAME);
      drop_now = 1;
      cycle();
      chk("uf_pulse", 32'(s_uf), 32'(1));
      chk("uf_blank", 32'(s_data), 32'(0));
      chk("uf_unlock", 32'(s_locked), 32'(0));
      wait_lock("relock_uf", 3 * FRAME);

      // Seven-pixel line: tlast on the 7th beat, 8th beat never sent.
      wait_pos("reach_l1p6", 6, 1, 2 * FRAME);
      tlast_flip = 1;
      cycle();
      chk("eol_pulse", 32'(s_ee), 32'(1));
      chk("eol_keeps_lock", 32'(s_locked), 32'(1));
      src_idx = 16;
      repeat (FRAME) cycle();
      wait_lock("relock_eol", 3 * FRAME);

      // Early SOF at line 1 pixel 3.
      wait_pos("reach_l1p3", 3, 1, 2 * FRAME);
      src_idx = 0; src_pix = DW'($urandom);
      held = src_pix;
      cycle();
      chk("resync_tready", 32'(s_tready), 32'(0));
      chk("resync_unlock", 32'(s_locked), 32'(0));
      chk("resync_no_eol", 32'(s_ee), 32'(0));
      wait_lock("relock_resync", 2 * FRAME);
      chk("resync_beat_first", 32'(s_data), 32'(held));

      // Reset pulse mid-line.
      wait_pos("reach_l2p4", 4, 2, 2 * FRAME);
      do_reset();
      wait_lock("relock_reset", 3 * FRAME);

      // Random gaps, stray SOFs and tlast errors.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(19, 0) == 0) drop_now = 1;
         if ($urandom_range(149, 0) == 0) begin
            src_idx = 0;
            src_pix = DW'($urandom);
         end
         if ($urandom_range(149, 0) == 0) tlast_flip = 1;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
